// File: rtl/multi_digit_led_driver_pkg.sv
// Shared constants for the multiplexed 7-segment LED driver.
//   PHASES_PER_SLOT : phases per digit slot
//   ANODE_ON/OFF    : anode drive levels (active-low)
//   DP_ON/OFF       : decimal point drive levels (active-low)
//   SEG_BLANK       : all segments dark
//   GLYPH_LUT       : hex nibble -> active-low {a,b,c,d,e,f,g}
package multi_digit_led_driver_pkg;

    localparam int PHASES_PER_SLOT = 16;

    localparam logic ANODE_ON  = 1'b0;
    localparam logic ANODE_OFF = 1'b1;
    localparam logic DP_ON     = 1'b0;
    localparam logic DP_OFF    = 1'b1;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Bit 6 is segment a, bit 0 is segment g; 0 = segment lit.
    localparam logic [6:0] GLYPH_LUT [0:15] = '{
        7'h01, 7'h4F, 7'h12, 7'h06,   // 0 1 2 3
        7'h4C, 7'h24, 7'h20, 7'h0F,   // 4 5 6 7
        7'h00, 7'h04, 7'h08, 7'h60,   // 8 9 A b
        7'h31, 7'h42, 7'h30, 7'h38    // C d E F
    };

endpackage

// File: rtl/multi_digit_led_driver_seg7_decoder.sv
// Combinational hex-to-7-segment decoder.
//   nibble : 4-bit hex value
//   seg_n  : active-low segments {a,b,c,d,e,f,g}
module seg7_decoder
    import multi_digit_led_driver_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = GLYPH_LUT[nibble];

endmodule

// File: rtl/multi_digit_led_driver.sv
// Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits.
// Each digit slot is 16 phases of CLK_DIV clocks; the first BLANK_PHASES
// phases keep the anode off while seg/dp settle, then the anode is on for
// up to `brightness` phases. New content is staged by `load` and only
// becomes visible at the start of a frame so a frame never tears.
//   clk, reset   : system clock, async active-low reset
//   data_in      : hex nibble per digit (digit k at [4k+3:4k])
//   dp_in        : decimal point request per digit (1 = lit)
//   digit_en     : per-digit enable (0 = blanked)
//   brightness   : on-phases per slot
//   load         : capture strobe for the four inputs above
//   busy         : staged content waiting for the next frame
//   frame_start  : one-cycle pulse as digit 0's slot begins
//   an, seg, dp  : active-low display drive
module multi_digit_led_driver
    import multi_digit_led_driver_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 20,
    parameter int BLANK_PHASES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [3:0]              brightness,
    input  logic                    load,
    output logic                    busy,
    output logic                    frame_start,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp
);

    localparam int PRESC_W = $clog2(CLK_DIV);
    localparam int DIGIT_W = $clog2(NUM_DIGITS);
    localparam int ON_MAX  = PHASES_PER_SLOT - BLANK_PHASES;

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] data;
        logic [NUM_DIGITS-1:0]   dp_req;
        logic [NUM_DIGITS-1:0]   en;
        logic [3:0]              bright;
    } cfg_t;

    logic [PRESC_W-1:0]    presc_q;
    logic [3:0]            phase_q;
    logic [DIGIT_W-1:0]    digit_q;
    logic                  tick;
    logic                  frame_cond;

    cfg_t                  cfg_in;
    cfg_t                  stage_q;
    cfg_t                  disp_q;
    cfg_t                  disp_next;

    logic [3:0]            cur_nibble;
    logic [6:0]            cur_seg_n;
    logic [4:0]            on_len;
    logic [4:0]            on_end;
    logic                  phase_lit;
    logic [NUM_DIGITS-1:0] an_next;

    assign tick       = (presc_q == PRESC_W'(CLK_DIV - 1));
    assign frame_cond = (presc_q == '0) && (phase_q == 4'd0) && (digit_q == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            phase_q <= '0;
            digit_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
            phase_q <= phase_q + 4'd1;
            if (phase_q == 4'd15) begin
                digit_q <= (digit_q == DIGIT_W'(NUM_DIGITS - 1)) ? '0 : digit_q + 1'b1;
            end
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    assign cfg_in = {data_in, dp_in, digit_en, brightness};

    // Display takes the staged copy at every frame start; when nothing is
    // pending the two are equal, so no extra qualification is needed.
    // A load in the same cycle lands in staging after the transfer and
    // therefore waits for the following frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_q <= '0;
            disp_q  <= '0;
            busy    <= 1'b0;
        end else begin
            if (frame_cond) begin
                disp_q <= stage_q;
            end
            if (load) begin
                stage_q <= cfg_in;
                busy    <= 1'b1;
            end else if (frame_cond) begin
                busy <= 1'b0;
            end
        end
    end

    // Outputs for the first cycle of a frame must already reflect the new
    // content, so decode from the value the display register is taking.
    assign disp_next  = frame_cond ? stage_q : disp_q;
    assign cur_nibble = disp_next.data[{digit_q, 2'b00} +: 4];

    seg7_decoder u_seg7_decoder (
        .nibble (cur_nibble),
        .seg_n  (cur_seg_n)
    );

    assign on_len    = (disp_next.bright > 4'(ON_MAX)) ? 5'(ON_MAX) : {1'b0, disp_next.bright};
    assign on_end    = 5'(BLANK_PHASES) + on_len;
    assign phase_lit = ({1'b0, phase_q} >= 5'(BLANK_PHASES)) && ({1'b0, phase_q} < on_end);

    always_comb begin
        an_next = {NUM_DIGITS{ANODE_OFF}};
        if (phase_lit && disp_next.en[digit_q]) begin
            an_next[digit_q] = ANODE_ON;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an          <= {NUM_DIGITS{ANODE_OFF}};
            seg         <= SEG_BLANK;
            dp          <= DP_OFF;
            frame_start <= 1'b0;
        end else begin
            an          <= an_next;
            seg         <= cur_seg_n;
            dp          <= disp_next.dp_req[digit_q] ? DP_ON : DP_OFF;
            frame_start <= frame_cond;
        end
    end

endmodule

// File: tb/tb_multi_digit_led_driver.sv
module tb_multi_digit_led_driver;

    localparam int ND    = 4;
    localparam int CD    = 2;
    localparam int BP    = 2;
    localparam int SLOT  = 16 * CD;
    localparam int FRAME = SLOT * ND;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = '0;
    logic [3:0]  brightness = '0;
    logic        load = 1'b0;
    logic        busy;
    logic        frame_start;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    always #5 clk = ~clk;

    multi_digit_led_driver #(
        .NUM_DIGITS   (ND),
        .CLK_DIV      (CD),
        .BLANK_PHASES (BP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .dp_in       (dp_in),
        .digit_en    (digit_en),
        .brightness  (brightness),
        .load        (load),
        .busy        (busy),
        .frame_start (frame_start),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dpr;
        logic [3:0]  en;
        logic [3:0]  br;
    } cfg_t;

    // Active-high segment glyphs {a,b,c,d,e,f,g}.
    logic [6:0] glyph_on [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    int total = 0;
    int bad   = 0;

    // Reference model: n counts clock edges since reset release. Edge n
    // follows the n-1'th counter state; content swaps at edges where that
    // state is the start of a frame, before any load at the same edge.
    cfg_t m_stage, m_disp;
    int   n, last_load, frame_edge;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            n          = 0;
            m_stage    = '0;
            m_disp     = '0;
            last_load  = -1;
            frame_edge = 0;
        end else begin
            n = n + 1;
            if ((n - 1) % FRAME == 0) begin
                m_disp     = m_stage;
                frame_edge = n;
            end
            if (load) begin
                m_stage   = {data_in, dp_in, digit_en, brightness};
                last_load = n;
            end
        end
    end

    // {an, seg, dp, frame_start, busy}
    function automatic logic [13:0] exp_vec();
        int         s, ph, dg, lim;
        logic [3:0] a;
        logic [6:0] sg;
        logic       d;
        if (!reset || n == 0) return {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0};
        s   = n - 1;
        ph  = (s / CD) % 16;
        dg  = (s / SLOT) % ND;
        lim = (m_disp.br > 16 - BP) ? 16 - BP : int'(m_disp.br);
        a   = 4'hF;
        if (ph >= BP && ph < BP + lim && m_disp.en[dg]) a[dg] = 1'b0;
        sg  = ~glyph_on[m_disp.data[4*dg +: 4]];
        d   = ~m_disp.dpr[dg];
        return {a, sg, d, (s % FRAME == 0), (last_load >= frame_edge)};
    endfunction

    task automatic drive_load(input logic [15:0] d, input logic [3:0] p,
                              input logic [3:0] e, input logic [3:0] b);
        data_in    = d;
        dp_in      = p;
        digit_en   = e;
        brightness = b;
        load       = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_frame(output bit ok);
        int w = 0;
        @(negedge clk);
        while (frame_start !== 1'b1 && w < 2 * FRAME) begin
            @(negedge clk);
            w++;
        end
        ok = (frame_start === 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (an !== 4'hF)         begin bad++; $display("FAIL reset_an got=%h exp=f", an); end
        total++; if (seg !== 7'h7F)       begin bad++; $display("FAIL reset_seg got=%h exp=7f", seg); end
        total++; if (dp !== 1'b1)         begin bad++; $display("FAIL reset_dp got=%b exp=1", dp); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        bit ok;
        int on0 = 0, fs_cnt = 0;
        drive_load(16'h1234, 4'h0, 4'hF, 4'd15);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", busy); end
        wait_frame(ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_wait got=timeout exp=frame_start"); end
        total++; if (seg !== 7'h4C) begin bad++; $display("FAIL basic_digit0 got=%h exp=4c", seg); end
        for (int i = 0; i < FRAME; i++) begin
            total++;
            if ({an, seg, dp, frame_start, busy} !== exp_vec()) begin
                bad++;
                $display("FAIL basic_cycle n=%0d got=%h exp=%h", n, {an, seg, dp, frame_start, busy}, exp_vec());
            end
            if (an === 4'b1110) on0++;
            if (frame_start === 1'b1) fs_cnt++;
            @(negedge clk);
        end
        total++; if (on0 !== 28)  begin bad++; $display("FAIL basic_an0_cycles got=%0d exp=28", on0); end
        total++; if (fs_cnt !== 1) begin bad++; $display("FAIL basic_fs_count got=%0d exp=1", fs_cnt); end
        total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL basic_period got=%b exp=1 at 128", frame_start); end
    endtask

    task automatic test_brightness();
        bit         ok;
        logic [3:0] brs [3] = '{4'd3, 4'd0, 4'd14};
        foreach (brs[k]) begin
            int low [ND];
            int multi = 0;
            int want;
            foreach (low[d]) low[d] = 0;
            want = CD * ((brs[k] > 16 - BP) ? 16 - BP : int'(brs[k]));
            drive_load(16'h8E0B, 4'h0, 4'hF, brs[k]);
            wait_frame(ok);
            total++; if (!ok) begin bad++; $display("FAIL bright_wait got=timeout exp=frame_start"); end
            for (int i = 0; i < FRAME; i++) begin
                total++;
                if ({an, seg, dp, frame_start, busy} !== exp_vec()) begin
                    bad++;
                    $display("FAIL bright_cycle n=%0d got=%h exp=%h", n, {an, seg, dp, frame_start, busy}, exp_vec());
                end
                for (int d = 0; d < ND; d++) if (an[d] === 1'b0) low[d]++;
                if ($countones(~an) > 1) multi++;
                @(negedge clk);
            end
            for (int d = 0; d < ND; d++) begin
                total++;
                if (low[d] !== want) begin
                    bad++;
                    $display("FAIL bright_on_cycles br=%0d digit=%0d got=%0d exp=%0d", brs[k], d, low[d], want);
                end
            end
            total++; if (multi !== 0) begin bad++; $display("FAIL bright_multi_anode got=%0d exp=0", multi); end
        end
    endtask

    task automatic test_enable_dp();
        bit ok;
        int low [ND];
        int dp_low = 0, dp_out = 0;
        foreach (low[d]) low[d] = 0;
        drive_load(16'h0F5C, 4'b0001, 4'b0101, 4'd15);
        wait_frame(ok);
        total++; if (!ok) begin bad++; $display("FAIL en_wait got=timeout exp=frame_start"); end
        for (int i = 0; i < FRAME; i++) begin
            total++;
            if ({an, seg, dp, frame_start, busy} !== exp_vec()) begin
                bad++;
                $display("FAIL en_cycle n=%0d got=%h exp=%h", n, {an, seg, dp, frame_start, busy}, exp_vec());
            end
            for (int d = 0; d < ND; d++) if (an[d] === 1'b0) low[d]++;
            if (dp === 1'b0) begin
                dp_low++;
                if (i >= SLOT) dp_out++;
            end
            @(negedge clk);
        end
        total++; if (low[1] !== 0)  begin bad++; $display("FAIL en_an1 got=%0d exp=0", low[1]); end
        total++; if (low[3] !== 0)  begin bad++; $display("FAIL en_an3 got=%0d exp=0", low[3]); end
        total++; if (low[0] !== 28) begin bad++; $display("FAIL en_an0 got=%0d exp=28", low[0]); end
        total++; if (low[2] !== 28) begin bad++; $display("FAIL en_an2 got=%0d exp=28", low[2]); end
        total++; if (dp_low !== SLOT) begin bad++; $display("FAIL en_dp_cycles got=%0d exp=%0d", dp_low, SLOT); end
        total++; if (dp_out !== 0)  begin bad++; $display("FAIL en_dp_outside got=%0d exp=0", dp_out); end
    endtask

    task automatic test_mid_frame();
        int w = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            total++;
            if ({an, seg, dp, frame_start, busy} !== exp_vec()) begin
                bad++;
                $display("FAIL mid_pre n=%0d got=%h exp=%h", n, {an, seg, dp, frame_start, busy}, exp_vec());
            end
        end
        drive_load(16'h5555, 4'h0, 4'h3, 4'd5);
        drive_load(16'hABCD, 4'h0, 4'hF, 4'd15);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b exp=1", busy); end
        do begin
            @(negedge clk);
            w++;
            total++;
            if ({an, seg, dp, frame_start, busy} !== exp_vec()) begin
                bad++;
                $display("FAIL mid_hold n=%0d got=%h exp=%h", n, {an, seg, dp, frame_start, busy}, exp_vec());
            end
        end while (frame_start !== 1'b1 && w < 2 * FRAME);
        total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL mid_wait got=timeout exp=frame_start"); end
        total++; if (seg !== 7'h42) begin bad++; $display("FAIL mid_digit0 got=%h exp=42", seg); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy_clear got=%b exp=0", busy); end
        for (int i = 0; i < FRAME; i++) begin
            total++;
            if ({an, seg, dp, frame_start, busy} !== exp_vec()) begin
                bad++;
                $display("FAIL mid_after n=%0d got=%h exp=%h", n, {an, seg, dp, frame_start, busy}, exp_vec());
            end
            @(negedge clk);
        end
    endtask

    task automatic test_load_on_frame_start();
        int busy_low = 0;
        total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL fsload_align got=%b exp=1", frame_start); end
        drive_load(16'h9E07, 4'b1010, 4'hF, 4'd8);
        for (int i = 0; i < FRAME - 1; i++) begin
            total++;
            if ({an, seg, dp, frame_start, busy} !== exp_vec()) begin
                bad++;
                $display("FAIL fsload_cycle n=%0d got=%h exp=%h", n, {an, seg, dp, frame_start, busy}, exp_vec());
            end
            if (busy !== 1'b1) busy_low++;
            @(negedge clk);
        end
        total++; if (busy_low !== 0) begin bad++; $display("FAIL fsload_busy_low got=%0d exp=0", busy_low); end
        total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL fsload_next_fs got=%b exp=1", frame_start); end
        total++; if (seg !== 7'h0F) begin bad++; $display("FAIL fsload_digit0 got=%h exp=0f", seg); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fsload_busy_clear got=%b exp=0", busy); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6 * FRAME; i++) begin
            @(negedge clk);
            total++;
            if ({an, seg, dp, frame_start, busy} !== exp_vec()) begin
                bad++;
                $display("FAIL rand_cycle n=%0d got=%h exp=%h", n, {an, seg, dp, frame_start, busy}, exp_vec());
            end
            if ($urandom_range(0, 29) == 0 || (n % FRAME == 0 && $urandom_range(0, 1) == 1)) begin
                data_in    = 16'($urandom);
                dp_in      = 4'($urandom);
                digit_en   = 4'($urandom);
                brightness = 4'($urandom);
                load       = 1'b1;
            end else begin
                load = 1'b0;
            end
        end
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        wait_frame(ok);
        drive_load(16'h1234, 4'h0, 4'hF, 4'd15);
        wait_frame(ok);
        total++; if (!ok) begin bad++; $display("FAIL rstmid_wait got=timeout exp=frame_start"); end
        for (int i = 0; i < 2 * SLOT + 8; i++) begin
            @(negedge clk);
            total++;
            if ({an, seg, dp, frame_start, busy} !== exp_vec()) begin
                bad++;
                $display("FAIL rstmid_pre n=%0d got=%h exp=%h", n, {an, seg, dp, frame_start, busy}, exp_vec());
            end
        end
        drive_load(16'hFFFF, 4'hF, 4'hF, 4'd15);
        total++; if (an !== 4'b1011) begin bad++; $display("FAIL rstmid_lit got=%b exp=1011", an); end
        total++; if (busy !== 1'b1)  begin bad++; $display("FAIL rstmid_pending got=%b exp=1", busy); end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        total++; if (an !== 4'hF)   begin bad++; $display("FAIL rstmid_an got=%h exp=f", an); end
        total++; if (seg !== 7'h7F) begin bad++; $display("FAIL rstmid_seg got=%h exp=7f", seg); end
        total++; if (dp !== 1'b1)   begin bad++; $display("FAIL rstmid_dp got=%b exp=1", dp); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < FRAME + 4; i++) begin
            @(negedge clk);
            total++;
            if ({an, seg, dp, frame_start, busy} !== exp_vec()) begin
                bad++;
                $display("FAIL rstmid_post n=%0d got=%h exp=%h", n, {an, seg, dp, frame_start, busy}, exp_vec());
            end
            if (i == 0 && frame_start !== 1'b1) begin
                bad++;
                $display("FAIL rstmid_first_fs got=%b exp=1", frame_start);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_brightness();
        test_enable_dp();
        test_mid_frame();
        test_load_on_frame_start();
        test_random();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
